dma_priority_arbiter: RTL and testbench

- Channel-request front end of the 8237-style DMA controller, directly upstream of the timing-control FSM.
- Conditions the four DREQ inputs with polarity, mask and software-request bits, and picks one winner by fixed or rotating priority.
- Presents the winner to the timing FSM as a one-hot VALID_DREQ, then holds that channel locked for the whole service.
- Drives the DACK pins and supplies the status-register request bits.

---
 rtl/dma_pkg.sv | 11 +
 rtl/dma_rotating_pick.sv | 20 ++
 rtl/dma_priority_arbiter.sv | 90 +++++++++
 tb/tb_dma_priority_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the DMA channel-request front end.
package dma_pkg;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {IDLE, PEND, SERV} arb_state_t;
  typedef logic [1:0] ch_t;

  function automatic logic [NUM_CH-1:0] onehot4(input ch_t c);
    onehot4 = 4'b0001 << c;
  endfunction
endpackage

// File: rtl/dma_rotating_pick.sv
// Combinational priority pick: search starts at ptr_i and wraps mod 4.
module dma_rotating_pick import dma_pkg::*; (
  input  logic [NUM_CH-1:0] req_i,
  input  ch_t               ptr_i,
  output ch_t               winner_o,
  output logic              any_o
);
  ch_t idx;

  // Walk from farthest to nearest offset so the nearest requester is written last.
  always_comb begin
    winner_o = ptr_i;
    idx      = ptr_i;
    any_o    = |req_i;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      idx = ptr_i + ch_t'(k);
      if (req_i[idx]) winner_o = idx;
    end
  end
endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237-style DREQ conditioning, fixed/rotating arbitration and DACK generation.
module dma_priority_arbiter import dma_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic              cmdDisable,
  input  logic              cmdRotating,
  input  logic              cmdDreqLow,
  input  logic              cmdDackHigh,
  input  logic              hrq,
  input  logic              validDACK,
  output logic [NUM_CH-1:0] VALID_DREQ,
  output logic [1:0]        activeCh,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] statusReq
);
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] status_q, sync_req, eff_req, dack_act;
  arb_state_t        state_q, state_d;
  ch_t               ach_q, ach_d, ptr_q, ptr_d, pick_ptr, winner;
  logic              dack_on_q, dack_on_d, any_req;

  assign sync_req = sync_q[SYNC_STAGES-1] ^ {NUM_CH{cmdDreqLow}};
  assign eff_req  = cmdDisable ? '0 : ((sync_req & ~maskReg) | requestReg);
  assign pick_ptr = cmdRotating ? ptr_q : ch_t'(0);

  dma_rotating_pick u_pick (
    .req_i    (eff_req),
    .ptr_i    (pick_ptr),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q    <= '0;
      status_q  <= '0;
      state_q   <= IDLE;
      ach_q     <= '0;
      ptr_q     <= '0;
      dack_on_q <= 1'b0;
    end else begin
      sync_q[0] <= DREQ;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      status_q  <= sync_req;
      state_q   <= state_d;
      ach_q     <= ach_d;
      ptr_q     <= ptr_d;
      dack_on_q <= dack_on_d;
    end
  end

  // Once PEND latches a winner it stays locked; only a drop before hrq lets go.
  always_comb begin
    state_d   = state_q;
    ach_d     = ach_q;
    ptr_d     = cmdRotating ? ptr_q : ch_t'(0);
    dack_on_d = dack_on_q;
    case (state_q)
      IDLE: if (any_req) begin
        ach_d   = winner;
        state_d = PEND;
      end
      PEND: begin
        if (hrq)                 state_d = SERV;
        else if (!eff_req[ach_q]) state_d = IDLE;
      end
      SERV: begin
        if (!hrq) begin
          state_d   = IDLE;
          dack_on_d = 1'b0;
          if (cmdRotating) ptr_d = ach_q + ch_t'(1);
        end else if (validDACK) begin
          dack_on_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign VALID_DREQ = (state_q == PEND || state_q == SERV) ? onehot4(ach_q) : '0;
  assign activeCh   = ach_q;
  assign statusReq  = status_q;
  assign dack_act   = dack_on_q ? onehot4(ach_q) : '0;
  assign DACK       = cmdDackHigh ? dack_act : ~dack_act;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Vector table + scoreboard bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;
  logic       CLK = 1'b0, RESET = 1'b1;
  logic [3:0] DREQ = '0, maskReg = '0, requestReg = '0;
  logic       cmdDisable = 0, cmdRotating = 0, cmdDreqLow = 0, cmdDackHigh = 0;
  logic       hrq = 0, validDACK = 0;
  logic [3:0] VALID_DREQ, DACK, statusReq;
  logic [1:0] activeCh;

  dma_priority_arbiter #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg), .requestReg(requestReg),
    .cmdDisable(cmdDisable), .cmdRotating(cmdRotating), .cmdDreqLow(cmdDreqLow),
    .cmdDackHigh(cmdDackHigh), .hrq(hrq), .validDACK(validDACK),
    .VALID_DREQ(VALID_DREQ), .activeCh(activeCh), .DACK(DACK), .statusReq(statusReq)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] dreq, mask, rreq;
    logic [5:0] ctl;  // {dis, rot, dlow, dhigh, hrq, vdack}
    logic [3:0] evd;
    logic [1:0] ach;
    logic [3:0] edack, estat;
  } vec_t;

  typedef struct {
    logic [3:0] vd;
    logic [1:0] ach;
    logic [3:0] dack, stat;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0, bad = 0;

  function automatic vec_t mk(input logic [3:0] dreq, mask, rreq, input logic [5:0] ctl,
                              input logic [3:0] evd, input logic [1:0] ach,
                              input logic [3:0] edack, estat);
    vec_t v;
    v.dreq = dreq; v.mask = mask; v.rreq = rreq; v.ctl = ctl;
    v.evd = evd; v.ach = ach; v.edack = edack; v.estat = estat;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      cmp({tag, ".vdreq"},  VALID_DREQ,        e.vd);
      cmp({tag, ".active"}, {2'b00, activeCh}, {2'b00, e.ach});
      cmp({tag, ".dack"},   DACK,              e.dack);
      cmp({tag, ".status"}, statusReq,         e.stat);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge CLK);
    DREQ = v.dreq; maskReg = v.mask; requestReg = v.rreq;
    {cmdDisable, cmdRotating, cmdDreqLow, cmdDackHigh, hrq, validDACK} = v.ctl;
    sbq.push_back('{vd: v.evd, ach: v.ach, dack: v.edack, stat: v.estat});
    @(posedge CLK);
    #2;
    check_out(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w;
    logic [3:0] oh, m;

    // Fixed priority contention; ch1 drops during service so ch3 wins next.
    tbl.push_back(mk(4'b1010, 4'h0, 4'h0, 6'b000000, 4'b0000, 2'd0, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b1010, 4'h0, 4'h0, 6'b000000, 4'b0000, 2'd0, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'b1010, 4'h0, 4'h0, 6'b000000, 4'b0010, 2'd1, 4'b1111, 4'b1010));
    tbl.push_back(mk(4'b1010, 4'h0, 4'h0, 6'b000010, 4'b0010, 2'd1, 4'b1111, 4'b1010));
    tbl.push_back(mk(4'b1000, 4'h0, 4'h0, 6'b000011, 4'b0010, 2'd1, 4'b1101, 4'b1010));
    tbl.push_back(mk(4'b1000, 4'h0, 4'h0, 6'b000010, 4'b0010, 2'd1, 4'b1101, 4'b1010));
    tbl.push_back(mk(4'b1000, 4'h0, 4'h0, 6'b000010, 4'b0010, 2'd1, 4'b1101, 4'b1000));
    tbl.push_back(mk(4'b1000, 4'h0, 4'h0, 6'b000000, 4'b0000, 2'd1, 4'b1111, 4'b1000));
    tbl.push_back(mk(4'b1000, 4'h0, 4'h0, 6'b000000, 4'b1000, 2'd3, 4'b1111, 4'b1000));
    tbl.push_back(mk(4'b1000, 4'h0, 4'h0, 6'b000010, 4'b1000, 2'd3, 4'b1111, 4'b1000));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 6'b000011, 4'b1000, 2'd3, 4'b0111, 4'b1000));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 6'b000000, 4'b0000, 2'd3, 4'b1111, 4'b1000));
    tbl.push_back(mk(4'b0000, 4'h0, 4'h0, 6'b000000, 4'b0000, 2'd3, 4'b1111, 4'b0000));
    // Rotating priority over five services: 0,1,2,3,0.
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 6'b010000, 4'b0000, 2'd3, 4'b1111, 4'b0000));
    tbl.push_back(mk(4'hF, 4'h0, 4'h0, 6'b010000, 4'b0000, 2'd3, 4'b1111, 4'b0000));
    for (int k = 0; k < 5; k++) begin
      w  = 2'(k % 4);
      oh = 4'b0001 << w;
      m  = (k == 4) ? 4'hF : 4'h0;
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, 6'b010000, oh,      w, 4'hF, 4'hF));
      tbl.push_back(mk(4'hF, 4'h0, 4'h0, 6'b010010, oh,      w, 4'hF, 4'hF));
      tbl.push_back(mk(4'hF, m,    4'h0, 6'b010011, oh,      w, ~oh,  4'hF));
      tbl.push_back(mk(4'hF, m,    4'h0, 6'b010000, 4'b0000, w, 4'hF, 4'hF));
    end
    tbl.push_back(mk(4'h0, 4'hF, 4'h0, 6'b000000, 4'b0000, 2'd0, 4'hF, 4'hF));
    tbl.push_back(mk(4'h0, 4'hF, 4'h0, 6'b000000, 4'b0000, 2'd0, 4'hF, 4'hF));
    tbl.push_back(mk(4'h0, 4'hF, 4'h0, 6'b000000, 4'b0000, 2'd0, 4'hF, 4'h0));
    // Masked DREQ with software request; status ignores mask.
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0100, 6'b000000, 4'b0100, 2'd2, 4'hF, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0100, 6'b000000, 4'b0100, 2'd2, 4'hF, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0100, 6'b000000, 4'b0100, 2'd2, 4'hF, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'b0001, 4'b0100, 6'b000010, 4'b0100, 2'd2, 4'hF, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'b0000, 6'b000000, 4'b0000, 2'd2, 4'hF, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'b0000, 6'b000000, 4'b0000, 2'd2, 4'hF, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'b0001, 4'b0000, 6'b000000, 4'b0000, 2'd2, 4'hF, 4'b0000));
    // Controller disable blocks software requests.
    tbl.push_back(mk(4'h0, 4'h0, 4'b0010, 6'b100000, 4'b0000, 2'd2, 4'hF, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'b0010, 6'b100000, 4'b0000, 2'd2, 4'hF, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'b0000, 6'b000000, 4'b0000, 2'd2, 4'hF, 4'h0));
    // DREQ active-low, DACK active-high.
    tbl.push_back(mk(4'b1110, 4'h0,    4'h0, 6'b001100, 4'b0001, 2'd0, 4'b0000, 4'b1111));
    tbl.push_back(mk(4'b1110, 4'h0,    4'h0, 6'b001110, 4'b0001, 2'd0, 4'b0000, 4'b1111));
    tbl.push_back(mk(4'b1110, 4'h0,    4'h0, 6'b001111, 4'b0001, 2'd0, 4'b0001, 4'b0001));
    tbl.push_back(mk(4'b1110, 4'h0,    4'h0, 6'b001110, 4'b0001, 2'd0, 4'b0001, 4'b0001));
    tbl.push_back(mk(4'b1110, 4'b0001, 4'h0, 6'b001100, 4'b0000, 2'd0, 4'b0000, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'hF,    4'h0, 6'b000000, 4'b0000, 2'd0, 4'b1111, 4'b1110));
    tbl.push_back(mk(4'b0000, 4'hF,    4'h0, 6'b000000, 4'b0000, 2'd0, 4'b1111, 4'b1110));
    tbl.push_back(mk(4'b0000, 4'hF,    4'h0, 6'b000000, 4'b0000, 2'd0, 4'b1111, 4'b0000));
    // Request withdrawn while pending.
    tbl.push_back(mk(4'h0, 4'h0, 4'b1000, 6'b000000, 4'b1000, 2'd3, 4'hF, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'b1000, 6'b000000, 4'b1000, 2'd3, 4'hF, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'b0000, 6'b000000, 4'b0000, 2'd3, 4'hF, 4'h0));
    tbl.push_back(mk(4'h0, 4'h0, 4'b0000, 6'b000000, 4'b0000, 2'd3, 4'hF, 4'h0));

    #3;
    sbq.push_back('{vd: 4'h0, ach: 2'd0, dack: 4'hF, stat: 4'h0});
    check_out("reset");
    @(negedge CLK);
    RESET = 1'b0;

    foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

    // Rotating service on ch1 moves the pointer to 2, then reset mid-service on ch2.
    run(mk(4'h0, 4'h0, 4'b0010, 6'b010000, 4'b0010, 2'd1, 4'hF,    4'h0), "rst.a");
    run(mk(4'h0, 4'h0, 4'b0010, 6'b010010, 4'b0010, 2'd1, 4'hF,    4'h0), "rst.b");
    run(mk(4'h0, 4'h0, 4'b0000, 6'b010000, 4'b0000, 2'd1, 4'hF,    4'h0), "rst.c");
    run(mk(4'h0, 4'h0, 4'b0100, 6'b010000, 4'b0100, 2'd2, 4'hF,    4'h0), "rst.d");
    run(mk(4'h0, 4'h0, 4'b0100, 6'b010010, 4'b0100, 2'd2, 4'hF,    4'h0), "rst.e");
    run(mk(4'h0, 4'h0, 4'b0100, 6'b010011, 4'b0100, 2'd2, 4'b1011, 4'h0), "rst.f");
    #1 RESET = 1'b1;
    #1;
    sbq.push_back('{vd: 4'h0, ach: 2'd0, dack: 4'hF, stat: 4'h0});
    check_out("rst.async");
    @(posedge CLK);
    @(negedge CLK);
    requestReg = 4'h0; hrq = 1'b0; validDACK = 1'b0;
    RESET = 1'b0;
    // Pointer was cleared by reset, so ch0 must win a full contention.
    run(mk(4'h0, 4'h0, 4'b1111, 6'b010000, 4'b0001, 2'd0, 4'hF, 4'h0), "rst.ptr");
    run(mk(4'h0, 4'h0, 4'b0000, 6'b010000, 4'b0000, 2'd0, 4'hF, 4'h0), "rst.drop");

    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard leftover=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
